tt_accum_gen: RTL and testbench

//  Parametrised input accumulator for the TT tile: sums an unsigned input stream into
//  an ACC_W-bit register with selectable wrap, saturate, integrate-and-dump and hold

---
 rtl/tt_accum_pkg.sv | 21 ++
 rtl/tt_accum_addsat.sv | 21 ++
 rtl/tt_accum_gen.sv | 120 ++++++++++++
 tb/tb_tt_accum_gen.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/tt_accum_pkg.sv
// Shared definitions for the TT tile accumulator: mode encodings and width helpers.
package tt_accum_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP = 2'b00,
        MODE_SAT  = 2'b01,
        MODE_DUMP = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    // Width of the byte index; never narrower than one bit.
    function automatic int sel_width(input int acc_w);
        return (acc_w / 8 > 1) ? $clog2(acc_w / 8) : 1;
    endfunction

    // Width of the dump-period sample counter (0..dump_len-1), never narrower than one bit.
    function automatic int cnt_width(input int dump_len);
        return (dump_len > 1) ? $clog2(dump_len) : 1;
    endfunction

endpackage

// File: rtl/tt_accum_addsat.sv
// Combinational accumulate step: ACC_W+1-bit add of zero-extended din, optional saturation.
module tt_accum_addsat #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 16
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [IN_W-1:0]  din,
    input  logic             sat_en,
    output logic [ACC_W-1:0] next_val,
    output logic             carry
);

    logic [ACC_W:0] sum;

    always_comb begin
        sum      = {1'b0, acc} + {{(ACC_W + 1 - IN_W){1'b0}}, din};
        carry    = sum[ACC_W];
        next_val = (sat_en && carry) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    end

endmodule

// File: rtl/tt_accum_gen.sv
// Input accumulator with wrap / saturate / integrate-and-dump / hold modes,
// sticky overflow flag, dump strobe and byte-select readout.
module tt_accum_gen
    import tt_accum_pkg::*;
#(
    parameter int IN_W     = 8,
    parameter int ACC_W    = 16,
    parameter int DUMP_LEN = 256
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [IN_W-1:0]             din,
    input  logic [1:0]                  mode,
    input  logic                        clr,
    input  logic [sel_width(ACC_W)-1:0] byte_sel,
    output logic [ACC_W-1:0]            acc_out,
    output logic [7:0]                  byte_out,
    output logic                        ovf,
    output logic                        dump_valid,
    output logic [ACC_W-1:0]            dump_data
);

    localparam int SEL_W  = sel_width(ACC_W);
    localparam int CNT_W  = cnt_width(DUMP_LEN);
    localparam int NBYTES = ACC_W / 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DUMP_LEN - 1);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dump_valid_q, dump_valid_d;
    logic [ACC_W-1:0] dump_data_q, dump_data_d;

    mode_e            mode_s;
    logic [ACC_W-1:0] step_val;
    logic             step_carry;

    assign mode_s = mode_e'(mode);

    tt_accum_addsat #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_addsat (
        .acc      (acc_q),
        .din      (din),
        .sat_en   (mode_s == MODE_SAT),
        .next_val (step_val),
        .carry    (step_carry)
    );

    always_comb begin
        acc_d        = acc_q;
        ovf_d        = ovf_q;
        cnt_d        = cnt_q;
        dump_valid_d = 1'b0;
        dump_data_d  = dump_data_q;

        // Leaving DUMP always discards the partial period count.
        if (mode_s != MODE_DUMP) begin
            cnt_d = '0;
        end

        if (clr) begin
            acc_d = '0;
            ovf_d = 1'b0;
            cnt_d = '0;
        end else if (en) begin
            case (mode_s)
                MODE_WRAP, MODE_SAT: begin
                    acc_d = step_val;
                    if (step_carry) ovf_d = 1'b1;
                end
                MODE_DUMP: begin
                    if (step_carry) ovf_d = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        dump_data_d  = step_val;
                        dump_valid_d = 1'b1;
                        acc_d        = '0;
                        cnt_d        = '0;
                    end else begin
                        acc_d = step_val;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            ovf_q        <= 1'b0;
            cnt_q        <= '0;
            dump_valid_q <= 1'b0;
            dump_data_q  <= '0;
        end else begin
            acc_q        <= acc_d;
            ovf_q        <= ovf_d;
            cnt_q        <= cnt_d;
            dump_valid_q <= dump_valid_d;
            dump_data_q  <= dump_data_d;
        end
    end

    // Indices beyond the last byte lane read as zero.
    always_comb begin
        byte_out = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (byte_sel == SEL_W'(i)) byte_out = acc_q[8*i +: 8];
        end
    end

    assign acc_out    = acc_q;
    assign ovf        = ovf_q;
    assign dump_valid = dump_valid_q;
    assign dump_data  = dump_data_q;

endmodule

// File: tb/tb_tt_accum_gen.sv
// Directed self-checking bench for tt_accum_gen (IN_W=8, ACC_W=16, DUMP_LEN=4).
module tb_tt_accum_gen;
    import tt_accum_pkg::*;

    localparam int IN_W     = 8;
    localparam int ACC_W    = 16;
    localparam int DUMP_LEN = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [IN_W-1:0]  din;
    logic [1:0]       mode;
    logic             clr;
    logic [0:0]       byte_sel;
    logic [ACC_W-1:0] acc_out;
    logic [7:0]       byte_out;
    logic             ovf;
    logic             dump_valid;
    logic [ACC_W-1:0] dump_data;

    int checks = 0;
    int errors = 0;

    tt_accum_gen #(
        .IN_W     (IN_W),
        .ACC_W    (ACC_W),
        .DUMP_LEN (DUMP_LEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .din        (din),
        .mode       (mode),
        .clr        (clr),
        .byte_sel   (byte_sel),
        .acc_out    (acc_out),
        .byte_out   (byte_out),
        .ovf        (ovf),
        .dump_valid (dump_valid),
        .dump_data  (dump_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; din = '0; mode = MODE_WRAP; clr = 1'b0; byte_sel = 1'b0;
        #3;
        chk("rst_acc", 32'(acc_out), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        chk("rst_dv", 32'(dump_valid), 32'h0);
        chk("rst_dd", 32'(dump_data), 32'h0);
        #10 rst_n = 1'b1;

        // WRAP: 258 x 0xFF = 0x100FE -> wraps to 0x00FE with overflow
        mode = MODE_WRAP; en = 1'b1; din = 8'hFF;
        repeat (258) step();
        chk("wrap_acc", 32'(acc_out), 32'h00FE);
        chk("wrap_ovf", 32'(ovf), 32'h1);
        byte_sel = 1'b1; #1;
        chk("wrap_byte1", 32'(byte_out), 32'h00);
        byte_sel = 1'b0; #1;
        chk("wrap_byte0", 32'(byte_out), 32'hFE);
        $display("wrap: acc=%h ovf=%0d", acc_out, ovf);

        // Asynchronous reset mid-run clears immediately
        rst_n = 1'b0; #2;
        chk("arst_acc", 32'(acc_out), 32'h0);
        chk("arst_ovf", 32'(ovf), 32'h0);
        chk("arst_dv", 32'(dump_valid), 32'h0);
        rst_n = 1'b1;
        $display("async reset: acc=%h ovf=%0d", acc_out, ovf);

        // SAT: 257 x 0xFF = 0xFFFF exactly (no carry); 258th saturates
        mode = MODE_SAT; en = 1'b1; din = 8'hFF;
        repeat (257) step();
        chk("sat257_acc", 32'(acc_out), 32'hFFFF);
        chk("sat257_ovf", 32'(ovf), 32'h0);
        step();
        chk("sat258_acc", 32'(acc_out), 32'hFFFF);
        chk("sat258_ovf", 32'(ovf), 32'h1);
        repeat (3) step();
        chk("sat_hold_acc", 32'(acc_out), 32'hFFFF);
        en = 1'b0; clr = 1'b1; step(); clr = 1'b0;
        chk("sat_clr_acc", 32'(acc_out), 32'h0);
        chk("sat_clr_ovf", 32'(ovf), 32'h0);
        $display("sat: cleared acc=%h ovf=%0d", acc_out, ovf);

        // clr beats a same-edge sample; HOLD freezes acc
        mode = MODE_WRAP; en = 1'b1; din = 8'h05; step();
        chk("wrap5_acc", 32'(acc_out), 32'h5);
        clr = 1'b1; din = 8'h55; step(); clr = 1'b0;
        chk("clr_en_acc", 32'(acc_out), 32'h0);
        din = 8'h05; step();
        mode = MODE_HOLD; din = 8'h07; step(); step();
        chk("hold_acc", 32'(acc_out), 32'h5);
        $display("hold: acc=%h", acc_out);

        // DUMP, period 4, with en gaps
        en = 1'b0; clr = 1'b1; step(); clr = 1'b0;
        mode = MODE_DUMP;
        en = 1'b1; din = 8'd10; step();
        en = 1'b0; step();
        en = 1'b1; din = 8'd20; step();
        din = 8'd30; step();
        en = 1'b0; step(); step();
        chk("dump3_acc", 32'(acc_out), 32'd60);
        chk("dump3_dv", 32'(dump_valid), 32'h0);
        en = 1'b1; din = 8'd40; step();
        chk("dump4_dv", 32'(dump_valid), 32'h1);
        chk("dump4_dd", 32'(dump_data), 32'd100);
        chk("dump4_acc", 32'(acc_out), 32'h0);
        en = 1'b0; step();
        chk("dump_pulse_end", 32'(dump_valid), 32'h0);
        chk("dump_dd_held", 32'(dump_data), 32'd100);
        $display("dump: dump_data=%0d", dump_data);

        // DUMP -> WRAP -> DUMP restarts a full period; acc carries over
        en = 1'b1; din = 8'd1; step(); step();
        mode = MODE_WRAP; en = 1'b0; step();
        mode = MODE_DUMP; en = 1'b1; din = 8'd1;
        repeat (3) step();
        chk("reentry3_acc", 32'(acc_out), 32'd5);
        chk("reentry3_dv", 32'(dump_valid), 32'h0);
        step();
        chk("reentry4_dv", 32'(dump_valid), 32'h1);
        chk("reentry4_dd", 32'(dump_data), 32'd6);
        $display("mode switch: dump_data=%0d", dump_data);

        // Reset mid-period: no pulse, fresh period afterwards
        en = 1'b0; step();
        en = 1'b1; din = 8'd1; step(); step();
        rst_n = 1'b0; #2;
        chk("midrst_acc", 32'(acc_out), 32'h0);
        chk("midrst_dv", 32'(dump_valid), 32'h0);
        chk("midrst_dd", 32'(dump_data), 32'h0);
        rst_n = 1'b1;
        repeat (3) step();
        chk("post_rst3_dv", 32'(dump_valid), 32'h0);
        chk("post_rst3_acc", 32'(acc_out), 32'd3);
        step();
        chk("post_rst4_dv", 32'(dump_valid), 32'h1);
        chk("post_rst4_dd", 32'(dump_data), 32'd4);
        $display("reset mid-period: dump_data=%0d", dump_data);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
